// File: rtl/traffic_sensor_conditioner_if.sv
// Lane request/feedback bundle between the sensor conditioner and its user.
// Carries raw detector levels, light feedback, conditioned sensors and monitors.
interface traffic_sensor_conditioner_if #(
    parameter int WAIT_W = 6
);
    logic              ew_left_raw;
    logic              ew_str_raw;
    logic              ns_raw;
    logic [1:0]        ew_left_light;
    logic [1:0]        ew_str_light;
    logic [1:0]        ns_light;
    logic              ew_left_sensor;
    logic              ew_str_sensor;
    logic              ns_sensor;
    logic [WAIT_W-1:0] ew_left_wait;
    logic [WAIT_W-1:0] ew_str_wait;
    logic [WAIT_W-1:0] ns_wait;
    logic              light_fault;

    modport master (
        output ew_left_raw, ew_str_raw, ns_raw,
        output ew_left_light, ew_str_light, ns_light,
        input  ew_left_sensor, ew_str_sensor, ns_sensor,
        input  ew_left_wait, ew_str_wait, ns_wait,
        input  light_fault
    );

    modport slave (
        input  ew_left_raw, ew_str_raw, ns_raw,
        input  ew_left_light, ew_str_light, ns_light,
        output ew_left_sensor, ew_str_sensor, ns_sensor,
        output ew_left_wait, ew_str_wait, ns_wait,
        output light_fault
    );
endinterface

// File: rtl/traffic_sensor_conditioner.sv
// Synchronise, debounce and latch vehicle calls for three lanes,
// with per-lane wait counters and a sticky light-fault monitor.
module tsc_lane #(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int WAIT_W          = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_raw,
    input  logic [1:0]        i_light,
    output logic              o_sensor,
    output logic [WAIT_W-1:0] o_wait
);
    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1
                      : $clog2(DEBOUNCE_CYCLES + 1);

    logic              r_s1;
    logic              r_s2;
    logic              r_db;
    logic [CW-1:0]     r_cnt;
    logic              r_call;
    logic              r_sensor;
    logic [WAIT_W-1:0] r_wait;

    logic              w_green;
    logic [CW-1:0]     w_cnt_inc;
    logic              w_db_next;
    logic [CW-1:0]     w_cnt_next;
    logic              w_call_next;
    logic [WAIT_W-1:0] w_wait_next;

    assign w_green   = (i_light == 2'b10);
    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_db_next   = r_db;
        w_cnt_next  = '0;
        w_call_next = r_call;
        w_wait_next = r_wait;
        if (r_s2 != r_db) begin
            if (w_cnt_inc == CW'(DEBOUNCE_CYCLES)) begin
                w_db_next = ~r_db;
            end else begin
                w_cnt_next = w_cnt_inc;
            end
        end
        // Green clears the call even on the edge the detector rises.
        if (w_green) begin
            w_call_next = 1'b0;
        end else if (w_db_next && !r_db) begin
            w_call_next = 1'b1;
        end
        if (w_green) begin
            w_wait_next = '0;
        end else if (r_call && (r_wait != '1)) begin
            w_wait_next = r_wait + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_db     <= 1'b0;
            r_cnt    <= '0;
            r_call   <= 1'b0;
            r_sensor <= 1'b0;
            r_wait   <= '0;
        end else begin
            r_s1     <= i_raw;
            r_s2     <= r_s1;
            r_db     <= w_db_next;
            r_cnt    <= w_cnt_next;
            r_call   <= w_call_next;
            r_sensor <= w_db_next | w_call_next;
            r_wait   <= w_wait_next;
        end
    end

    assign o_sensor = r_sensor;
    assign o_wait   = r_wait;
endmodule

module traffic_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int WAIT_W          = 6
) (
    input logic clk,
    input logic reset,
    traffic_sensor_conditioner_if.slave bus
);
    logic w_any_invalid;
    logic w_multi_lit;
    logic r_fault;

    tsc_lane #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .WAIT_W         (WAIT_W)
    ) u_ew_left (
        .clk     (clk),
        .reset   (reset),
        .i_raw   (bus.ew_left_raw),
        .i_light (bus.ew_left_light),
        .o_sensor(bus.ew_left_sensor),
        .o_wait  (bus.ew_left_wait)
    );

    tsc_lane #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .WAIT_W         (WAIT_W)
    ) u_ew_str (
        .clk     (clk),
        .reset   (reset),
        .i_raw   (bus.ew_str_raw),
        .i_light (bus.ew_str_light),
        .o_sensor(bus.ew_str_sensor),
        .o_wait  (bus.ew_str_wait)
    );

    tsc_lane #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .WAIT_W         (WAIT_W)
    ) u_ns (
        .clk     (clk),
        .reset   (reset),
        .i_raw   (bus.ns_raw),
        .i_light (bus.ns_light),
        .o_sensor(bus.ns_sensor),
        .o_wait  (bus.ns_wait)
    );

    assign w_any_invalid = (bus.ew_left_light == 2'b11)
                         | (bus.ew_str_light == 2'b11)
                         | (bus.ns_light == 2'b11);

    // Any pair of non-red lanes is a conflict.
    assign w_multi_lit = ((bus.ew_left_light != 2'b00) && (bus.ew_str_light != 2'b00))
                       | ((bus.ew_left_light != 2'b00) && (bus.ns_light != 2'b00))
                       | ((bus.ew_str_light != 2'b00) && (bus.ns_light != 2'b00));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= r_fault | w_any_invalid | w_multi_lit;
        end
    end

    assign bus.light_fault = r_fault;
endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Random and directed stimulus for traffic_sensor_conditioner,
// checked every cycle against a lane-level behavioural model.
module tb_traffic_sensor_conditioner;
    localparam int DC     = 3;
    localparam int WAIT_W = 6;
    localparam int WMAX   = (1 << WAIT_W) - 1;

    logic clk;
    logic reset;

    traffic_sensor_conditioner_if #(.WAIT_W(WAIT_W)) bus ();

    traffic_sensor_conditioner #(
        .DEBOUNCE_CYCLES(DC),
        .WAIT_W         (WAIT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // stimulus for the next edge: lane 0 ew_left, 1 ew_str, 2 ns
    bit st_rst;
    bit st_raw[3];
    int st_light[3];

    // reference state, valid after the most recent edge
    int raw_hist[3][$];
    int m_db[3];
    int m_run[3];
    int m_call[3];
    int m_sens[3];
    int m_wait[3];
    int m_fault;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_edge();
        int lit;
        if (st_rst) begin
            m_fault = 0;
            for (int i = 0; i < 3; i++) begin
                raw_hist[i].delete();
                raw_hist[i].push_back(0);
                raw_hist[i].push_back(0);
                m_db[i] = 0; m_run[i] = 0; m_call[i] = 0;
                m_sens[i] = 0; m_wait[i] = 0;
            end
            return;
        end
        lit = 0;
        for (int i = 0; i < 3; i++) begin
            int seen;
            int new_db;
            bit green;
            green = (st_light[i] == 2);
            if (st_light[i] != 0) lit++;
            if (st_light[i] == 3) m_fault = 1;
            // detector level as seen two edges after sampling
            seen = raw_hist[i][0];
            new_db = m_db[i];
            m_run[i] = (seen != m_db[i]) ? m_run[i] + 1 : 0;
            if (m_run[i] == DC) begin
                new_db = 1 - m_db[i];
                m_run[i] = 0;
            end
            if (green) m_wait[i] = 0;
            else if (m_call[i] == 1) m_wait[i] = (m_wait[i] < WMAX) ? m_wait[i] + 1 : WMAX;
            if (green) m_call[i] = 0;
            else if (new_db == 1 && m_db[i] == 0) m_call[i] = 1;
            m_db[i] = new_db;
            m_sens[i] = (new_db | m_call[i]);
            void'(raw_hist[i].pop_front());
            raw_hist[i].push_back(int'(st_raw[i]));
        end
        if (lit > 1) m_fault = 1;
    endfunction

    task automatic tick();
        @(negedge clk);
        chk("ew_left_sensor", int'(bus.ew_left_sensor), m_sens[0]);
        chk("ew_str_sensor", int'(bus.ew_str_sensor), m_sens[1]);
        chk("ns_sensor", int'(bus.ns_sensor), m_sens[2]);
        chk("ew_left_wait", int'(bus.ew_left_wait), m_wait[0]);
        chk("ew_str_wait", int'(bus.ew_str_wait), m_wait[1]);
        chk("ns_wait", int'(bus.ns_wait), m_wait[2]);
        chk("light_fault", int'(bus.light_fault), m_fault);
        reset             = st_rst;
        bus.ew_left_raw   = st_raw[0];
        bus.ew_str_raw    = st_raw[1];
        bus.ns_raw        = st_raw[2];
        bus.ew_left_light = 2'(st_light[0]);
        bus.ew_str_light  = 2'(st_light[1]);
        bus.ns_light      = 2'(st_light[2]);
        model_edge();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic idle();
        for (int i = 0; i < 3; i++) begin
            st_raw[i] = 1'b0;
            st_light[i] = 0;
        end
    endtask

    initial begin
        int hold_raw[3];
        int hold_light;
        n_checks = 0;
        n_fail   = 0;
        idle();
        st_rst = 1'b1;
        st_raw[0] = 1'b1; st_raw[1] = 1'b1; st_raw[2] = 1'b1;
        reset             = 1'b1;
        bus.ew_left_raw   = 1'b1;
        bus.ew_str_raw    = 1'b1;
        bus.ns_raw        = 1'b1;
        bus.ew_left_light = 2'b00;
        bus.ew_str_light  = 2'b00;
        bus.ns_light      = 2'b00;
        model_edge();
        tick();
        chk("rst_ns_sensor", int'(bus.ns_sensor), 0);
        chk("rst_fault", int'(bus.light_fault), 0);
        st_rst = 1'b0;
        ticks(5);
        chk("rise_not_early", int'(bus.ew_left_sensor), 0);
        tick();
        chk("rise_r5", int'(bus.ew_left_sensor), 1);
        ticks(4);

        // glitch on ew_str
        st_rst = 1'b1; idle(); tick();
        st_rst = 1'b0; tick();
        st_raw[1] = 1'b1; ticks(2);
        st_raw[1] = 1'b0; ticks(8);
        chk("glitch_sensor", int'(bus.ew_str_sensor), 0);

        // call memory on ns, then served by green
        st_raw[2] = 1'b1; ticks(6);
        st_raw[2] = 1'b0; ticks(10);
        chk("ns_call_held", int'(bus.ns_sensor), 1);
        st_light[2] = 2; tick();
        st_light[2] = 0; tick();
        chk("ns_served", int'(bus.ns_sensor), 0);
        chk("ns_wait_clr", int'(bus.ns_wait), 0);

        // saturation
        st_raw[2] = 1'b1; ticks(6);
        st_raw[2] = 1'b0; ticks(100);
        chk("ns_wait_sat", int'(bus.ns_wait), WMAX);
        st_light[2] = 2; ticks(2);
        st_light[2] = 0;

        // presence during green
        st_light[0] = 2;
        st_raw[0] = 1'b1; ticks(10);
        st_raw[0] = 1'b0; ticks(10);
        chk("green_wait", int'(bus.ew_left_wait), 0);
        chk("no_fault_yet", int'(bus.light_fault), 0);
        st_light[0] = 0; tick();

        // conflicting lights, then invalid code alone
        st_light[1] = 2; st_light[2] = 1; tick();
        idle(); ticks(4);
        chk("fault_sticky", int'(bus.light_fault), 1);
        st_rst = 1'b1; tick();
        st_rst = 1'b0; st_light[0] = 3; tick();
        idle(); ticks(2);
        chk("fault_invalid", int'(bus.light_fault), 1);

        // random traffic with mostly legal light sequences
        hold_raw[0] = 0; hold_raw[1] = 0; hold_raw[2] = 0;
        hold_light = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (hold_raw[i] == 0) begin
                    st_raw[i] = 1'($urandom_range(0, 1));
                    hold_raw[i] = $urandom_range(1, 9);
                end
                hold_raw[i]--;
            end
            if (hold_light == 0) begin
                int g;
                hold_light = $urandom_range(1, 25);
                for (int i = 0; i < 3; i++) st_light[i] = 0;
                if ($urandom_range(0, 19) == 0) begin
                    for (int i = 0; i < 3; i++) st_light[i] = $urandom_range(0, 3);
                end else begin
                    g = $urandom_range(0, 3);
                    if (g < 3) st_light[g] = $urandom_range(1, 2);
                end
            end
            hold_light--;
            st_rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        st_rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/traffic_sensor_conditioner.md
# traffic_sensor_conditioner

Upstream front end for `traffic_light_controller`. It synchronises and debounces the three raw vehicle-detector inputs and latches each arrival as a pending call until that lane shows green. It drives the controller's `ew_left_sensor`, `ew_str_sensor` and `ns_sensor` inputs, and takes the controller's three 2-bit light outputs back as feedback. Per-lane wait counters and a sticky light-fault flag are provided for monitoring.

## Interface
- `DEBOUNCE_CYCLES`, default 3: consecutive disagreeing cycles needed to flip the debounced level; must be >= 1.
- `WAIT_W`, default 6: width of each wait counter.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ew_left_raw`, `ew_str_raw`, `ns_raw`  in  1 each  raw loop-detector levels, asynchronous to `clk`.
- `ew_left_light`, `ew_str_light`, `ns_light`  in  2 each  controller light feedback: 00 red, 01 yellow, 10 green, 11 invalid.
- `ew_left_sensor`, `ew_str_sensor`, `ns_sensor`  out  1 each  conditioned request, to the controller.
- `ew_left_wait`, `ew_str_wait`, `ns_wait`  out  WAIT_W each  cycles the pending call has waited, saturating.
- `light_fault`  out  1  sticky conflicting/invalid light indication.

## Operation
Three identical lane instances, one per lane. Each lane has:
- **Synchroniser:** 2-flop chain `s1 <= raw`, `s2 <= s1`.
- **Debouncer:** register `db` and a counter.
  - On each edge where `s2 != db`, the counter increments.
  - When the incremented value equals DEBOUNCE_CYCLES, `db` toggles and the counter clears.
  - Any edge with `s2 == db` clears the counter.
- **Call latch:** register `call`.
  - Set on the edge where `db` goes 0->1, if the lane light != 10.
  - Cleared on any edge where the lane light == 10. Clear wins over set.
  - A `db` fall does not clear `call`; a vehicle that has passed the loop keeps its request.
- **Sensor output:** register `sensor <= db_next | call_next`.
  - While the lane is green, `call` is 0, so the sensor tracks live presence. This lets the controller extend green and see traffic end.
- **Wait counter:**
  - Increments on each edge where `call` (pre-edge value) is 1 and the light != 10.
  - Saturates at 2^WAIT_W-1.
  - Clears on the edge where `call` clears.
- **Light fault:** `light_fault` is set on any edge where either condition holds, and clears only on reset:
  - any light input == 11, or
  - more than one lane light != 00.
- Light encodings 01 and 11 count as "not green" for call/wait purposes.

## Timing
- **Reset:** every flop clears to 0 (`s1`, `s2`, `db`, counters, `call`, `sensor`, `wait`, `light_fault`). All outputs read 0 after the first edge with `reset`=1.
  - Reset mid-operation discards pending calls and wait counts.
- **Raw-to-sensor latency:** raw stable from before edge E0 gives `s2` after E1 and `db` after E1+DEBOUNCE_CYCLES.
  - `sensor` changes at the same edge as `db`: E4 for the default of 3, i.e. 2+DEBOUNCE_CYCLES edges.
  - Same latency for falling presence when no call is pending.
- **Glitch rejection:** raw pulses (or drops) shorter than DEBOUNCE_CYCLES cycles at `s2` never reach `sensor`.
- **Green feedback:** the light == 10 seen at edge E clears `call` and `wait` at E; `sensor` equals `db` after E.
- **Simultaneous events:**
  - `db` rise while green does not latch a call.
  - `db` rise on the edge the light leaves green (light sampled != 10) latches a call.
- **Wait counter:** first increment on the edge after `call` is set; holds at the saturation value until cleared.
- **No lane interaction:** lanes do not interact; `light_fault` is the only cross-lane logic.

## Test plan
1. **Reset:** `reset`=1 for 2 cycles with all raws=1 -> all outputs 0. Release at edge R: `sensor`s rise after edge R+5, with lights all 00.
2. **Glitch:** `ew_str_raw`=1 for 2 cycles, lights 00 -> `ew_str_sensor` stays 0 and `ew_str_wait` stays 0 throughout.
3. **Call memory:** `ns_raw`=1 for 6 cycles then 0, `ns_light`=00.
   - `ns_sensor`=1 from 5 edges after the rise and stays 1 after `db` falls.
   - `ns_wait` counts 0,1,2,...
   - Drive `ns_light`=10: the next edge gives `ns_sensor`=0 and `ns_wait`=0.
4. **Presence during green:** `ew_left_light`=10, `ew_left_raw`=1 for 10 cycles.
   - `ew_left_sensor` rises 5 edges after the raw rise and falls 5 edges after the raw fall.
   - `ew_left_wait` stays 0.
5. **Saturation:** WAIT_W=6, NS call pending with `ns_light`=00 for 100 cycles -> `ns_wait` reaches 63 and holds 63.
6. **Fault:**
   - `ew_str_light`=10 with `ns_light`=01 -> `light_fault`=1 next edge, and stays 1 after all lights return to 00.
   - After reset, `ew_left_light`=11 alone also sets `light_fault`.
